step_rx: RTL and testbench
==========================

# step_rx

Step/direction pulse receiver and decoder: it is the receive end of the step/dir interface the motion core drives toward stepper drivers. It synchronises external `step_in`/`dir_in`, qualifies pulse widths and direction setup, and tracks a signed 32-bit position. It also measures the interval between accepted steps, so a host or loopback checker can read back position and speed. It is used for closed-loop verification of generated step trains and for slaving an axis to an external controller.

## Interface
- `MIN_LOW`, 50: minimum low cycles (synchronised) before a rising edge is accepted.
- `MIN_HIGH`, 50: minimum high cycles; a shorter pulse flags an error.
- `DIR_SETUP`, 20: cycles `dir` must be stable before an accepted rising edge.
- `TIMEOUT`, 16777215: period counter saturation value; reaching it means stopped.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `step_in` in 1: asynchronous external step pulse.
- `dir_in` in 1: asynchronous external direction; 0 = +1, 1 = -1.
- `set_position` in 1: load `position` from `data_in`.
- `data_in` in 32 signed: preload value.
- `position` out 32 signed: accumulated position.
- `period` out 32: cycles between the last two accepted steps.
- `period_valid` out 1: `period` is meaningful.
- `stopped` out 1: no accepted step for `TIMEOUT` cycles.
- `step_strobe` out 1: one-cycle pulse per accepted step.
- `dir_out` out 1: direction latched at the last accepted step.
- `err` out 3: sticky flags. [0] short low / glitch, [1] short high, [2] dir setup violation.
- `err_clr` in 1: clears `err`.

## Operation
- `step_in` and `dir_in` each pass through a two-flop synchroniser (`s1`, `s2`). A third register, `s3`, holds the previous `s2` for edge detection.
- FSM states:
  - LOW: `low_cnt` counts up, saturating at 16 bits. On a rise, go to HIGH and clear `high_cnt`.
  - HIGH: `high_cnt` counts up. On a fall, go to LOW and clear `low_cnt`. If `high_cnt+1 < MIN_HIGH` at the fall, set `err[1]`.
- Reset state is LOW with `low_cnt = MIN_LOW`, so the first edge after reset qualifies.
- Rise acceptance:
  - A rise is accepted only if `low_cnt >= MIN_LOW`.
  - Otherwise set `err[0]`; the step is not counted, but the FSM still enters HIGH.
- Direction setup: `dir_stable_cnt` resets to 0 on any `dir` change and saturates at 16 bits. If it is below `DIR_SETUP` at an accepted rise, set `err[2]`. The step is still counted, using the synchronised `dir` value.
- On each accepted step:
  - `step_strobe` = 1.
  - `position` ±1, two's-complement wrap at ±2^31.
  - `dir_out` updated.
- Period measurement:
  - `per_cnt` increments every cycle and saturates at `TIMEOUT`.
  - On an accepted step: `period <= per_cnt + 1`, then `per_cnt <= 0`.
  - `period_valid` goes to 1 on the second accepted step after reset, `set_position`, or timeout.
- Timeout: when `per_cnt == TIMEOUT`, set `stopped = 1`, `period_valid = 0`, `period = 0`. The next accepted step clears `stopped` but does not set `period_valid`.
- `set_position`:
  - Loads `position <= data_in`.
  - Clears `period_valid` and the step-count-since-load.
  - Has priority over a same-cycle step, which is dropped; `step_strobe` stays 0.
- Error flags: `err` bits set sticky. `err_clr` clears them; a same-cycle set wins.
- Reset values: `position` 0, `period` 0, `period_valid` 0, `stopped` 1, `step_strobe` 0, `dir_out` 0, `err` 0, FSM LOW.

## Timing
- Latency: the `step_in` rise is first sampled into `s1` at edge N. `step_strobe` and the `position` update are registered at edge N+2 and visible after it.
- `dir_in` has the same two-cycle synchroniser latency, so setup is measured in synchronised cycles.
- `period` is exact in `clk` cycles between strobes. A constant input period P gives `period == P`.
- No handshake: outputs are level registers and are valid every cycle.
- Reset mid-pulse: the FSM returns to LOW. A `step_in` still high after reset produces no strobe until a fall followed by a qualified rise.

## Structure
- Package `vp2_motion_pkg`:
  - FSM state enum (LOW, HIGH).
  - Default constants `STEP_MIN_LOW`, `STEP_MIN_HIGH`, `STEP_DIR_SETUP`, `STEP_TIMEOUT`.
  - Error bit indices.
- Sub-module `sync2`: a 1-bit two-flop synchroniser, instantiated twice.
- Everything else lives in `step_rx`.

## Test plan
- Reset, then 10 pulses (300 high / 200 low, `dir=0`): `position` = 10, `period` = 500, `period_valid` = 1 after the 2nd strobe, `err` = 0.
- `set_position` with `data_in=-5`, then 3 pulses with `dir=1`: `position` = -8. A `set_position` coinciding with a strobe cycle drops that step.
- 10-cycle low glitch between pulses: `err[0]` set, step not counted. A 20-cycle high pulse sets `err[1]` and is counted.
- `dir` toggled 5 cycles before a rise: `err[2]` set, step counted in the new direction. `err_clr` returns `err` to 0.
- No pulses for `TIMEOUT` cycles (reduce to 1000 in the bench): `stopped` = 1, `period_valid` = 0. The next pulse clears `stopped`; the one after gives a valid `period`.
- `position` preloaded to 0x7FFFFFFF, one +1 step: `position` = 0x80000000.

Source files
------------

// File: rtl/vp2_motion_pkg.sv
// Shared motion definitions for the step/dir receiver.
//   - step_state_t : pulse qualifier FSM states (LOW, HIGH)
//   - STEP_*       : default timing constants, in clk cycles
//   - ERR_*        : bit positions inside the sticky err vector
//   - sat_inc16    : 16-bit saturating increment used by the qualifier counters
package vp2_motion_pkg;

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } step_state_t;

   localparam int unsigned STEP_MIN_LOW   = 50;
   localparam int unsigned STEP_MIN_HIGH  = 50;
   localparam int unsigned STEP_DIR_SETUP = 20;
   localparam int unsigned STEP_TIMEOUT   = 16777215;

   localparam int ERR_SHORT_LOW  = 0;
   localparam int ERR_SHORT_HIGH = 1;
   localparam int ERR_DIR_SETUP  = 2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/step_rx_if.sv
// Signal bundle between a step/dir source/host and the step_rx receiver.
//   step_in, dir_in     : external step pulse and direction (asynchronous)
//   set_position, data_in : position preload request and value
//   err_clr             : clears the sticky error flags
//   position, period, period_valid, stopped, step_strobe, dir_out, err : receiver status
// There is no handshake: every output is a level register valid on every cycle,
// and inputs are sampled on every rising clk edge.
// Modports: master = source/host side, slave = receiver side.
interface step_rx_if;

   logic               step_in;
   logic               dir_in;
   logic               set_position;
   logic signed [31:0] data_in;
   logic               err_clr;

   logic signed [31:0] position;
   logic        [31:0] period;
   logic               period_valid;
   logic               stopped;
   logic               step_strobe;
   logic               dir_out;
   logic        [2:0]  err;

   modport master (
      output step_in, dir_in, set_position, data_in, err_clr,
      input  position, period, period_valid, stopped, step_strobe, dir_out, err
   );

   modport slave (
      input  step_in, dir_in, set_position, data_in, err_clr,
      output position, period, period_valid, stopped, step_strobe, dir_out, err
   );

endinterface

// File: rtl/step_rx_sync2.sv
// sync2: 1-bit two-flop synchroniser for an asynchronous input.
//   clk : destination clock
//   d   : asynchronous input
//   q   : synchronised output (two clk cycles of latency)
// The flops carry no reset so a level held through reset is not seen as a
// fresh edge once reset is released.
module sync2 (
   input  logic clk,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      s1 <= d;
      q  <= s1;
   end

endmodule

// File: rtl/step_rx.sv
// step_rx: step/direction pulse receiver and decoder.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : step_rx_if slave modport (step/dir inputs, preload, status outputs)
//   fsm_state  : current pulse qualifier state, for observation
// Synchronises step/dir, qualifies low/high widths and direction setup,
// tracks a signed 32-bit position and measures the interval between
// accepted steps, with a timeout that flags the axis as stopped.
module step_rx
   import vp2_motion_pkg::*;
#(
   parameter int unsigned MIN_LOW   = STEP_MIN_LOW,
   parameter int unsigned MIN_HIGH  = STEP_MIN_HIGH,
   parameter int unsigned DIR_SETUP = STEP_DIR_SETUP,
   parameter int unsigned TIMEOUT   = STEP_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   step_rx_if.slave    bus,
   output step_state_t fsm_state
);

   logic step_s2, step_s3;
   logic dir_s2, dir_s3;

   sync2 u_step_sync (.clk(clk), .d(bus.step_in), .q(step_s2));
   sync2 u_dir_sync  (.clk(clk), .d(bus.dir_in),  .q(dir_s2));

   // Previous synchronised values for edge detection; unreset like the
   // synchronisers so a pulse held high across reset produces no rise.
   always_ff @(posedge clk) begin
      step_s3 <= step_s2;
      dir_s3  <= dir_s2;
   end

   logic rise, fall;
   assign rise = step_s2 & ~step_s3;
   assign fall = ~step_s2 & step_s3;

   step_state_t state, state_next;
   logic [15:0] low_cnt, low_cnt_next;
   logic [15:0] high_cnt, high_cnt_next;
   logic [15:0] dir_stable_cnt;
   logic        rise_ok;
   logic        step_ok;
   logic [2:0]  err_set;

   assign fsm_state = state;

   // Qualifier state and counters. low_cnt starts at MIN_LOW and
   // dir_stable_cnt at DIR_SETUP so the first edge after reset qualifies.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_LOW;
         low_cnt        <= 16'(MIN_LOW);
         high_cnt       <= 16'd0;
         dir_stable_cnt <= 16'(DIR_SETUP);
      end else begin
         state    <= state_next;
         low_cnt  <= low_cnt_next;
         high_cnt <= high_cnt_next;
         if (dir_s2 != dir_s3) dir_stable_cnt <= 16'd0;
         else                  dir_stable_cnt <= sat_inc16(dir_stable_cnt);
      end
   end

   always_comb begin
      state_next    = state;
      low_cnt_next  = low_cnt;
      high_cnt_next = high_cnt;
      rise_ok       = 1'b0;
      err_set       = 3'b000;
      case (state)
         ST_LOW: begin
            if (rise) begin
               // A short low still moves to HIGH so the matching fall is tracked.
               state_next    = ST_HIGH;
               high_cnt_next = 16'd0;
               if (32'(low_cnt) >= MIN_LOW) rise_ok = 1'b1;
               else                          err_set[ERR_SHORT_LOW] = 1'b1;
            end else if (fall) begin
               // Only reachable when reset landed mid-pulse: the low time starts now.
               low_cnt_next = 16'd0;
            end else begin
               low_cnt_next = sat_inc16(low_cnt);
            end
         end
         ST_HIGH: begin
            if (fall) begin
               state_next   = ST_LOW;
               low_cnt_next = 16'd0;
               if (32'(high_cnt) + 32'd1 < MIN_HIGH) err_set[ERR_SHORT_HIGH] = 1'b1;
            end else begin
               high_cnt_next = sat_inc16(high_cnt);
            end
         end
         default: state_next = ST_LOW;
      endcase
      if (rise_ok && (32'(dir_stable_cnt) < DIR_SETUP)) err_set[ERR_DIR_SETUP] = 1'b1;
   end

   // A preload in the same cycle swallows the step entirely.
   assign step_ok = rise_ok & ~bus.set_position;

   logic signed [31:0] position;
   logic        [31:0] period;
   logic        [31:0] per_cnt;
   logic               period_valid;
   logic               stopped;
   logic               step_strobe;
   logic               dir_out;
   logic        [2:0]  err;
   logic               have_first;   // one step seen since reset/load/timeout

   always_ff @(posedge clk) begin
      if (reset) begin
         position     <= 32'sd0;
         period       <= 32'd0;
         per_cnt      <= 32'd0;
         period_valid <= 1'b0;
         stopped      <= 1'b1;
         step_strobe  <= 1'b0;
         dir_out      <= 1'b0;
         err          <= 3'b000;
         have_first   <= 1'b0;
      end else begin
         step_strobe <= step_ok;

         if (bus.set_position) begin
            position     <= bus.data_in;
            period_valid <= 1'b0;
            have_first   <= 1'b0;
         end else if (step_ok) begin
            position   <= dir_s2 ? position - 32'sd1 : position + 32'sd1;
            dir_out    <= dir_s2;
            have_first <= 1'b1;
            if (have_first) period_valid <= 1'b1;
         end

         if (step_ok) begin
            period  <= per_cnt + 32'd1;
            per_cnt <= 32'd0;
            stopped <= 1'b0;
         end else if (per_cnt == TIMEOUT) begin
            // Held every cycle while saturated; the next step restarts the count.
            stopped      <= 1'b1;
            period       <= 32'd0;
            period_valid <= 1'b0;
            have_first   <= 1'b0;
         end else begin
            per_cnt <= per_cnt + 32'd1;
         end

         // Sticky flags; a new event in the clearing cycle survives.
         err <= (err & ~{3{bus.err_clr}}) | err_set;
      end
   end

   assign bus.position     = position;
   assign bus.period       = period;
   assign bus.period_valid = period_valid;
   assign bus.stopped      = stopped;
   assign bus.step_strobe  = step_strobe;
   assign bus.dir_out      = dir_out;
   assign bus.err          = err;

endmodule

// File: tb/tb_step_rx.sv
module tb_step_rx;
   import vp2_motion_pkg::*;

   logic        clk;
   logic        reset;
   step_state_t fsm_state;
   int          checks;
   int          failures;
   int          strobe_cnt;
   int          base;

   step_rx_if bus();

   step_rx #(.TIMEOUT(1000)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // strobe monitor, sampled away from the active edge
   always @(negedge clk) if (bus.step_strobe) strobe_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int h, input int l);
      bus.step_in = 1'b1;
      tick(h);
      bus.step_in = 1'b0;
      tick(l);
   endtask

   task automatic load(input logic [31:0] v);
      bus.set_position = 1'b1;
      bus.data_in      = v;
      tick(1);
      bus.set_position = 1'b0;
   endtask

   task automatic clear_err();
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      int          high;
      int          low;
      bit          dir;
      bit          do_load;
      logic [31:0] load_val;
      logic [31:0] exp_pos;
      bit          exp_pv;
      logic [31:0] exp_per;
   } vec_t;

   vec_t vecs[13];

   initial begin
      checks     = 0;
      failures   = 0;
      strobe_cnt = 0;
      bus.step_in      = 1'b0;
      bus.dir_in       = 1'b0;
      bus.set_position = 1'b0;
      bus.data_in      = 32'sd0;
      bus.err_clr      = 1'b0;
      reset            = 1'b1;
      tick(5);
      reset = 1'b0;

      // reset state
      check("rst_position", bus.position, 32'd0);
      check("rst_period", bus.period, 32'd0);
      check("rst_period_valid", 32'(bus.period_valid), 32'd0);
      check("rst_stopped", 32'(bus.stopped), 32'd1);
      check("rst_step_strobe", 32'(bus.step_strobe), 32'd0);
      check("rst_dir_out", 32'(bus.dir_out), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_fsm", 32'(fsm_state), 32'(ST_LOW));
      tick(10);

      // vector table: ten forward pulses, then a preload to -5 and three reverse pulses
      for (int i = 0; i < 10; i++)
         vecs[i] = '{300, 200, 1'b0, 1'b0, 32'd0, 32'(i + 1), (i >= 1), 32'd500};
      vecs[10] = '{300, 200, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, 32'd500};
      vecs[11] = '{300, 200, 1'b1, 1'b0, 32'd0,         32'hFFFF_FFF9, 1'b1, 32'd500};
      vecs[12] = '{300, 200, 1'b1, 1'b0, 32'd0,         32'hFFFF_FFF8, 1'b1, 32'd500};

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].dir != bus.dir_in) begin
            bus.dir_in = vecs[i].dir;
            tick(50);
         end
         if (vecs[i].do_load) begin
            load(vecs[i].load_val);
            check($sformatf("v%0d_load", i), bus.position, vecs[i].load_val);
            check($sformatf("v%0d_load_pv", i), 32'(bus.period_valid), 32'd0);
         end
         base = strobe_cnt;
         pulse(vecs[i].high, vecs[i].low);
         check($sformatf("v%0d_strobes", i), 32'(strobe_cnt - base), 32'd1);
         check($sformatf("v%0d_position", i), bus.position, vecs[i].exp_pos);
         check($sformatf("v%0d_err", i), 32'(bus.err), 32'd0);
         check($sformatf("v%0d_period_valid", i), 32'(bus.period_valid), 32'(vecs[i].exp_pv));
         check($sformatf("v%0d_dir_out", i), 32'(bus.dir_out), 32'(vecs[i].dir));
         if (vecs[i].exp_pv)
            check($sformatf("v%0d_period", i), bus.period, vecs[i].exp_per);
      end

      // preload landing on the strobe cycle drops that step (position -8 -> 100)
      base = strobe_cnt;
      bus.step_in = 1'b1;
      tick(2);
      bus.set_position = 1'b1;
      bus.data_in      = 32'sd100;
      tick(1);
      bus.set_position = 1'b0;
      check("drop_position", bus.position, 32'd100);
      check("drop_strobe", 32'(bus.step_strobe), 32'd0);
      tick(297);
      bus.step_in = 1'b0;
      tick(200);
      check("drop_strobes", 32'(strobe_cnt - base), 32'd0);
      check("drop_pv", 32'(bus.period_valid), 32'd0);

      // strobe latency: registered on the third edge after the input rises
      bus.step_in = 1'b1;
      tick(2);
      check("lat_early", 32'(bus.step_strobe), 32'd0);
      tick(1);
      check("lat_strobe", 32'(bus.step_strobe), 32'd1);
      check("lat_position", bus.position, 32'd99);
      check("lat_fsm_high", 32'(fsm_state), 32'(ST_HIGH));
      tick(1);
      check("lat_single", 32'(bus.step_strobe), 32'd0);
      tick(296);
      bus.step_in = 1'b0;
      tick(200);
      check("lat_pv_first", 32'(bus.period_valid), 32'd0);

      // short low glitch: rejected; short high pulse: counted but flagged
      pulse(300, 10);
      check("glitch_pre_pos", bus.position, 32'd98);
      pulse(300, 200);
      check("glitch_pos", bus.position, 32'd98);
      check("glitch_err", 32'(bus.err), 32'b001);
      pulse(20, 200);
      check("short_high_pos", bus.position, 32'd97);
      check("short_high_err", 32'(bus.err), 32'b011);
      clear_err();
      check("err_clr_1", 32'(bus.err), 32'd0);

      // direction changed 5 cycles before the rise: flagged, counted forward
      bus.dir_in = 1'b0;
      tick(5);
      pulse(300, 200);
      check("dir_setup_pos", bus.position, 32'd98);
      check("dir_setup_err", 32'(bus.err), 32'b100);
      check("dir_setup_dir_out", 32'(bus.dir_out), 32'd0);
      clear_err();
      check("err_clr_2", 32'(bus.err), 32'd0);

      // timeout with TIMEOUT=1000
      tick(1100);
      check("to_stopped", 32'(bus.stopped), 32'd1);
      check("to_pv", 32'(bus.period_valid), 32'd0);
      check("to_period", bus.period, 32'd0);
      pulse(300, 200);
      check("to_first_stopped", 32'(bus.stopped), 32'd0);
      check("to_first_pv", 32'(bus.period_valid), 32'd0);
      check("to_first_pos", bus.position, 32'd99);
      pulse(300, 200);
      check("to_second_pv", 32'(bus.period_valid), 32'd1);
      check("to_second_period", bus.period, 32'd500);
      check("to_second_pos", bus.position, 32'd100);

      // positive wrap
      load(32'h7FFF_FFFF);
      pulse(300, 200);
      check("wrap_pos", bus.position, 32'h8000_0000);

      // reset while step_in is high: no strobe until a fall and a qualified rise
      bus.step_in = 1'b1;
      tick(100);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      check("midrst_position", bus.position, 32'd0);
      check("midrst_stopped", 32'(bus.stopped), 32'd1);
      check("midrst_fsm", 32'(fsm_state), 32'(ST_LOW));
      base = strobe_cnt;
      tick(100);
      check("midrst_no_strobe", 32'(strobe_cnt - base), 32'd0);
      bus.step_in = 1'b0;
      tick(200);
      check("midrst_fall_err", 32'(bus.err), 32'd0);
      pulse(300, 200);
      check("midrst_pos", bus.position, 32'd1);
      check("midrst_strobes", 32'(strobe_cnt - base), 32'd1);
      check("midrst_err", 32'(bus.err), 32'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
